// File: rtl/vx_fifo_queue_mc.sv
// vx_fifo_queue_mc: NUM_CH independent FIFOs sharing one RAM addressed {ch, ptr}; async read head.
// Optional FIFO_QUEUE_MC_PROTECT_EN: drop overflowing pushes / underflowing pops and flag them on err.

// Simulation-only protocol checks for the queue.
module vx_fifo_queue_mc_chk #(
    parameter int NUM_CH = 4,
    parameter int CHW    = 2
) (
    input logic              clk,
    input logic              reset,
    input logic              push,
    input logic [CHW-1:0]    push_ch,
    input logic              pop,
    input logic [CHW-1:0]    pop_ch,
    input logic [NUM_CH-1:0] full,
    input logic [NUM_CH-1:0] empty
);
    // Checks are sampled at the edge that would commit the operation.
    always @(posedge clk) begin
        if (!reset) begin
            if (NUM_CH > 1) begin
                assert (!push || (int'(push_ch) < NUM_CH))
                    else $error("vx_fifo_queue_mc: push_ch %0d out of range", push_ch);
                assert (!pop || (int'(pop_ch) < NUM_CH))
                    else $error("vx_fifo_queue_mc: pop_ch %0d out of range", pop_ch);
            end
`ifndef FIFO_QUEUE_MC_PROTECT_EN
            assert (!(push && full[push_ch] && !(pop && (pop_ch == push_ch))))
                else $error("vx_fifo_queue_mc: push to full channel %0d", push_ch);
            assert (!(pop && empty[pop_ch]))
                else $error("vx_fifo_queue_mc: pop from empty channel %0d", pop_ch);
`endif
        end
    end
endmodule

module vx_fifo_queue_mc #(
    parameter int DATAW     = 32,
    parameter int SIZE      = 4,
    parameter int NUM_CH    = 4,
    parameter int ALM_FULL  = SIZE - 1,
    parameter int ALM_EMPTY = 1,
    parameter int CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ADDRW     = $clog2(SIZE),
    parameter int SIZEW     = $clog2(SIZE + 1),
    parameter int LUTRAM    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [CHW-1:0]          push_ch,
    input  logic [DATAW-1:0]        data_in,
    input  logic                    pop,
    input  logic [CHW-1:0]          pop_ch,
    output logic [DATAW-1:0]        data_out,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       alm_empty,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       alm_full,
    output logic [NUM_CH*SIZEW-1:0] size,
    output logic [1:0]              err
);
    localparam int              RAM_DEPTH   = NUM_CH * SIZE;
    localparam logic [SIZEW-1:0] SIZE_C      = SIZEW'(SIZE);
    localparam logic [SIZEW-1:0] ALM_FULL_C  = SIZEW'(ALM_FULL);
    localparam logic [SIZEW-1:0] ALM_EMPTY_C = SIZEW'(ALM_EMPTY);
    localparam logic [SIZEW-1:0] ONE_C       = SIZEW'(1);
    localparam logic [ADDRW-1:0] PTR_ONE_C   = ADDRW'(1);

    logic [CHW-1:0]       push_idx_s;
    logic [CHW-1:0]       pop_idx_s;
    logic [ADDRW-1:0]     wr_ptr_r [NUM_CH];
    logic [ADDRW-1:0]     rd_ptr_r [NUM_CH];
    logic [SIZEW-1:0]     count_r [NUM_CH];
    logic [SIZEW-1:0]     count_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]    do_push_s;
    logic [NUM_CH-1:0]    do_pop_s;
    logic [NUM_CH-1:0]    push_ok_s;
    logic [NUM_CH-1:0]    pop_ok_s;
    logic [NUM_CH-1:0]    empty_r;
    logic [NUM_CH-1:0]    alm_empty_r;
    logic [NUM_CH-1:0]    full_r;
    logic [NUM_CH-1:0]    alm_full_r;
    logic                 wr_en_s;
    logic [CHW+ADDRW-1:0] wr_addr_s;
    logic [CHW+ADDRW-1:0] rd_addr_s;
    logic [DATAW-1:0]     rd_data_s;

    // A single-channel build ignores the channel selects entirely.
    assign push_idx_s = (NUM_CH == 1) ? {CHW{1'b0}} : push_ch;
    assign pop_idx_s  = (NUM_CH == 1) ? {CHW{1'b0}} : pop_ch;

    // Per-channel operation decode, guarding and next occupancy.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            do_push_s[c] = push && (push_idx_s == CHW'(c));
            do_pop_s[c]  = pop && (pop_idx_s == CHW'(c));
`ifdef FIFO_QUEUE_MC_PROTECT_EN
            // A same-channel pop frees the slot, so a full channel may still accept the push.
            push_ok_s[c] = do_push_s[c] && (!full_r[c] || do_pop_s[c]);
            pop_ok_s[c]  = do_pop_s[c] && !empty_r[c];
`else
            push_ok_s[c] = do_push_s[c];
            pop_ok_s[c]  = do_pop_s[c];
`endif
            if (push_ok_s[c] && !pop_ok_s[c]) begin
                count_nxt_s[c] = count_r[c] + ONE_C;
            end else if (!push_ok_s[c] && pop_ok_s[c]) begin
                count_nxt_s[c] = count_r[c] - ONE_C;
            end else begin
                count_nxt_s[c] = count_r[c];
            end
        end
    end

    assign wr_en_s   = (|push_ok_s) && !reset;
    assign wr_addr_s = {push_idx_s, wr_ptr_r[push_idx_s]};
    assign rd_addr_s = {pop_idx_s, rd_ptr_r[pop_idx_s]};

    generate
        if (LUTRAM != 0) begin : g_lutram
            (* ram_style = "distributed" *) logic [DATAW-1:0] mem_r [RAM_DEPTH];
            // Write port; contents are deliberately left unreset.
            always_ff @(posedge clk) begin
                if (wr_en_s) begin
                    mem_r[wr_addr_s] <= data_in;
                end
            end
            assign rd_data_s = mem_r[rd_addr_s];
        end else begin : g_bram
            (* ram_style = "block" *) logic [DATAW-1:0] mem_r [RAM_DEPTH];
            // Write port; contents are deliberately left unreset.
            always_ff @(posedge clk) begin
                if (wr_en_s) begin
                    mem_r[wr_addr_s] <= data_in;
                end
            end
            assign rd_data_s = mem_r[rd_addr_s];
        end
    endgenerate

    // Pointers, counts and registered flags, all committed on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_r[c] <= {ADDRW{1'b0}};
                rd_ptr_r[c] <= {ADDRW{1'b0}};
                count_r[c]  <= {SIZEW{1'b0}};
            end
            empty_r     <= {NUM_CH{1'b1}};
            alm_empty_r <= {NUM_CH{1'b1}};
            full_r      <= {NUM_CH{1'b0}};
            alm_full_r  <= {NUM_CH{1'b0}};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_ok_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + PTR_ONE_C;
                end
                if (pop_ok_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + PTR_ONE_C;
                end
                count_r[c]     <= count_nxt_s[c];
                empty_r[c]     <= (count_nxt_s[c] == {SIZEW{1'b0}});
                alm_empty_r[c] <= (count_nxt_s[c] <= ALM_EMPTY_C);
                full_r[c]      <= (count_nxt_s[c] == SIZE_C);
                alm_full_r[c]  <= (count_nxt_s[c] >= ALM_FULL_C);
            end
        end
    end

`ifdef FIFO_QUEUE_MC_PROTECT_EN
    logic [1:0] err_r;

    // Sticky {underflow, overflow}; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 2'b00;
        end else begin
            err_r <= err_r | {|(do_pop_s & ~pop_ok_s), |(do_push_s & ~push_ok_s)};
        end
    end

    assign err = err_r;
`else
    assign err = 2'b00;
`endif

    // Pack per-channel occupancy onto the flat size bus.
    always_comb begin
        size = {(NUM_CH*SIZEW){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            size[c*SIZEW +: SIZEW] = count_r[c];
        end
    end

    assign data_out  = rd_data_s;
    assign empty     = empty_r;
    assign alm_empty = alm_empty_r;
    assign full      = full_r;
    assign alm_full  = alm_full_r;

    vx_fifo_queue_mc_chk #(
        .NUM_CH (NUM_CH),
        .CHW    (CHW)
    ) u_chk (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_ch (push_idx_s),
        .pop     (pop),
        .pop_ch  (pop_idx_s),
        .full    (full_r),
        .empty   (empty_r)
    );
endmodule

// File: tb/tb_vx_fifo_queue_mc.sv
// Directed bench for vx_fifo_queue_mc (NUM_CH=4, SIZE=4, DATAW=32).
// size bus layout: {ch3, ch2, ch1, ch0}, 3 bits each.
module tb_vx_fifo_queue_mc;
    localparam int DATAW = 32;
    localparam int CHW   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             push;
    logic [CHW-1:0]   push_ch;
    logic [DATAW-1:0] data_in;
    logic             pop;
    logic [CHW-1:0]   pop_ch;
    logic [DATAW-1:0] data_out;
    logic [3:0]       empty;
    logic [3:0]       alm_empty;
    logic [3:0]       full;
    logic [3:0]       alm_full;
    logic [11:0]      size;
    logic [1:0]       err;
    logic [31:0]      vec [4];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vx_fifo_queue_mc dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_ch   (push_ch),
        .data_in   (data_in),
        .pop       (pop),
        .pop_ch    (pop_ch),
        .data_out  (data_out),
        .empty     (empty),
        .alm_empty (alm_empty),
        .full      (full),
        .alm_full  (alm_full),
        .size      (size),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic p, input logic [1:0] pc, input logic [31:0] d,
                       input logic q, input logic [1:0] qc);
        push    = p;
        push_ch = pc;
        data_in = d;
        pop     = q;
        pop_ch  = qc;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [1:0] ch, input logic [31:0] exp);
        pop_ch = ch;
        #1;
        chk(tag, data_out, exp);
    endtask

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        push_ch = 2'd0;
        pop_ch  = 2'd0;
        data_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_empty",     32'(empty),     32'hF);
        chk("rst_alm_empty", 32'(alm_empty), 32'hF);
        chk("rst_full",      32'(full),      32'h0);
        chk("rst_alm_full",  32'(alm_full),  32'h0);
        chk("rst_size",      32'(size),      32'h0);
        chk("rst_err",       32'(err),       32'h0);

        // Fill ch2 and drain it in order.
        vec[0] = 32'hA0A0_0000; vec[1] = 32'hB1B1_0001;
        vec[2] = 32'hC2C2_0002; vec[3] = 32'hD3D3_0003;
        cyc(1'b1, 2'd2, vec[0], 1'b0, 2'd0);
        peek("t2_head_first", 2'd2, vec[0]);
        chk("t2_alm_empty_1", 32'(alm_empty), 32'hF);
        cyc(1'b1, 2'd2, vec[1], 1'b0, 2'd0);
        chk("t2_alm_empty_2", 32'(alm_empty), 32'hB);
        cyc(1'b1, 2'd2, vec[2], 1'b0, 2'd0);
        chk("t2_alm_full_3",  32'(alm_full),  32'h4);
        chk("t2_full_3",      32'(full),      32'h0);
        cyc(1'b1, 2'd2, vec[3], 1'b0, 2'd0);
        chk("t2_full_4",      32'(full),      32'h4);
        chk("t2_alm_full_4",  32'(alm_full),  32'h4);
        chk("t2_empty_4",     32'(empty),     32'hB);
        chk("t2_size_4",      32'(size),      32'h100);
        for (int i = 0; i < 4; i++) begin
            peek("t2_pop_data", 2'd2, vec[i]);
            cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        end
        chk("t2_drained_empty", 32'(empty), 32'hF);
        chk("t2_drained_size",  32'(size),  32'h0);

        // Interleaved ch0 / ch3 traffic, then push ch0 while popping ch3.
        cyc(1'b1, 2'd0, 32'h10, 1'b0, 2'd0);
        cyc(1'b1, 2'd3, 32'h30, 1'b0, 2'd0);
        cyc(1'b1, 2'd0, 32'h11, 1'b0, 2'd0);
        cyc(1'b1, 2'd3, 32'h31, 1'b0, 2'd0);
        chk("t3_size",      32'(size),      32'h402);
        chk("t3_alm_empty", 32'(alm_empty), 32'h6);
        peek("t3_ch0_head0", 2'd0, 32'h10);
        peek("t3_ch3_head0", 2'd3, 32'h30);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        peek("t3_ch0_head1", 2'd0, 32'h11);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("t3_empty", 32'(empty), 32'h7);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
        peek("t3_ch3_head1", 2'd3, 32'h31);
        chk("t3_size_ch3_1", 32'(size), 32'h200);
        cyc(1'b1, 2'd0, 32'h12, 1'b1, 2'd3);
        chk("t5_size",  32'(size),  32'h001);
        chk("t5_empty", 32'(empty), 32'hE);
        peek("t5_ch0_head", 2'd0, 32'h12);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("t5_drained", 32'(empty), 32'hF);

        // Full ch1: simultaneous push+pop keeps it full; order survives pointer wrap.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'd1, 32'hE000_0000 + 32'(i), 1'b0, 2'd0);
        end
        chk("t4_full",      32'(full), 32'h2);
        chk("t4_size_full", 32'(size), 32'h020);
        for (int i = 0; i < 4; i++) begin
            peek("t4_head_pp", 2'd1, 32'hE000_0000 + 32'(i));
            cyc(1'b1, 2'd1, 32'hE000_0004 + 32'(i), 1'b1, 2'd1);
            chk("t4_size_pp", 32'(size), 32'h020);
            chk("t4_full_pp", 32'(full), 32'h2);
        end
        for (int i = 0; i < 4; i++) begin
            peek("t4_wrap_data", 2'd1, 32'hE000_0004 + 32'(i));
            cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        end
        chk("t4_drained_empty", 32'(empty), 32'hF);
        chk("t4_drained_size",  32'(size),  32'h0);

        // Reset mid-operation with a push in the reset cycle discards everything.
        cyc(1'b1, 2'd0, 32'h55, 1'b0, 2'd0);
        cyc(1'b1, 2'd0, 32'h66, 1'b0, 2'd0);
        reset   = 1'b1;
        push    = 1'b1;
        push_ch = 2'd0;
        data_in = 32'h77;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        chk("mid_rst_empty", 32'(empty), 32'hF);
        chk("mid_rst_size",  32'(size),  32'h0);
        cyc(1'b1, 2'd0, 32'h88, 1'b0, 2'd0);
        peek("mid_rst_head", 2'd0, 32'h88);
        chk("mid_rst_size1", 32'(size), 32'h001);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("mid_rst_drained", 32'(empty), 32'hF);

`ifdef FIFO_QUEUE_MC_PROTECT_EN
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2'd2, 32'hF000_0000 + 32'(i), 1'b0, 2'd0);
        end
        cyc(1'b1, 2'd2, 32'hF000_0004, 1'b0, 2'd0);
        chk("p_ovf_size", 32'(size), 32'h100);
        chk("p_ovf_err",  32'(err),  32'h1);
        peek("p_ovf_head", 2'd2, 32'hF000_0000);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        chk("p_unf_err",  32'(err),  32'h3);
        chk("p_unf_size", 32'(size), 32'h100);
        cyc(1'b1, 2'd3, 32'hF5, 1'b1, 2'd3);
        chk("p_empty_pp_size", 32'(size), 32'h300);
        peek("p_empty_pp_head", 2'd3, 32'hF5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("p_rst_err",  32'(err),  32'h0);
        chk("p_rst_size", 32'(size), 32'h0);
`else
        chk("err_tied", 32'(err), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
